// File: rtl/packet_framer.sv
// Serial packet framer: hunts for SYNC_WORD on a 1-bit stream, captures PKT_BITS payload bits
// and hands each packet off through a one-deep valid/ready register. Optional macro: PKT_PARITY_EN.
module packet_framer #(
    parameter logic [31:0] SYNC_WORD = 32'hA5A5A5A5,
    parameter int          PKT_BITS  = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data,
    input  logic                pkt_ready,
    output logic                pkt_valid,
    output logic [PKT_BITS-1:0] pkt_data,
    output logic [15:0]         pkt_port,
    output logic [7:0]          pkt_session,
    output logic [31:0]         pkt_cnt,
    output logic [7:0]          drop_cnt,
    output logic                busy
);

    localparam int                CNT_W    = $clog2(PKT_BITS + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(PKT_BITS - 1);
    localparam int                PORT_MSB = PKT_BITS - 1 - 64;
    localparam int                SESS_MSB = PKT_BITS - 1 - 136;

    typedef enum logic {
        S_HUNT,
        S_CAPTURE
    } state_t;

    state_t                r_state;
    // Only the 31 newest window bits are kept: the oldest bit is shifted out before any compare.
    logic [30:0]           r_win;
    logic [PKT_BITS-2:0]   r_shreg;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_busy;

    logic                  r_pkt_valid;
    logic [PKT_BITS-1:0]   r_pkt_data;
    logic [15:0]           r_pkt_port;
    logic [7:0]            r_pkt_session;
    logic [31:0]           r_pkt_cnt;
    logic [7:0]            r_drop_cnt;

    logic [31:0]           w_win_next;
    logic [PKT_BITS-1:0]   w_shift_next;
    logic                  w_sync_hit;
    logic                  w_done;
    logic                  w_accept;
    logic                  w_par_ok;
    logic                  w_load;
    logic                  w_drop;

    assign w_win_next   = {r_win, data};
    assign w_shift_next = {r_shreg, data};
    assign w_sync_hit   = (r_state == S_HUNT) && (w_win_next == SYNC_WORD);
    assign w_done       = (r_state == S_CAPTURE) && (r_bit_cnt == LAST_BIT);
    assign w_accept     = r_pkt_valid && pkt_ready;

`ifdef PKT_PARITY_EN
    // Last payload bit makes the whole packet even parity.
    assign w_par_ok = ~^w_shift_next;
`else
    assign w_par_ok = 1'b1;
`endif

    // A completed packet loads if the slot is free or drains on this same edge.
    assign w_load = w_done && w_par_ok && (!r_pkt_valid || pkt_ready);
    assign w_drop = w_done && !w_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_HUNT;
            r_win     <= '0;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_HUNT: begin
                    r_win <= w_win_next[30:0];
                    if (w_sync_hit) begin
                        r_state   <= S_CAPTURE;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_shreg   <= w_shift_next[PKT_BITS-2:0];
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (w_done) begin
                        // Payload never feeds the window, so hunting restarts from a clean slate.
                        r_state   <= S_HUNT;
                        r_win     <= '0;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_HUNT;
                    r_win   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_valid   <= 1'b0;
            r_pkt_data    <= '0;
            r_pkt_port    <= '0;
            r_pkt_session <= '0;
            r_pkt_cnt     <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_load) begin
                r_pkt_valid   <= 1'b1;
                r_pkt_data    <= w_shift_next;
                r_pkt_port    <= w_shift_next[PORT_MSB -: 16];
                r_pkt_session <= w_shift_next[SESS_MSB -: 8];
                r_pkt_cnt     <= r_pkt_cnt + 32'd1;
            end else if (w_accept) begin
                r_pkt_valid <= 1'b0;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign pkt_valid   = r_pkt_valid;
    assign pkt_data    = r_pkt_data;
    assign pkt_port    = r_pkt_port;
    assign pkt_session = r_pkt_session;
    assign pkt_cnt     = r_pkt_cnt;
    assign drop_cnt    = r_drop_cnt;
    assign busy        = r_busy;

endmodule
